// File: rtl/inst_fetch_buffer.sv
// Fetch-stage instruction buffer: strobes the MDR, captures each instruction word
// into a small first-word-fall-through FIFO, and hands words to decode via valid/ready.
module inst_fetch_buffer #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 67,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mdr_valid,
   output logic             MDR_rd,
   input  logic [WIDTH-1:0] inst,
   output logic             mdr_taken,
   input  logic             flush,
   output logic [WIDTH-1:0] dec_inst,
   output logic             dec_valid,
   input  logic             dec_ready,
   output logic [CW-1:0]    count
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {IDLE, READ} state_t;

   state_t           state, state_nx;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push, pop;

   // Full check uses the pre-pop count, so a full FIFO never starts a read
   // even when decode is draining an entry in the same cycle.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (mdr_valid && !flush && !mdr_taken && (count < FULL)) state_nx = READ;
         READ: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   assign MDR_rd    = (state == READ);
   assign push      = (state == READ) && !flush;
   assign pop       = dec_valid && dec_ready && !flush;
   assign dec_valid = (count != '0);
   assign dec_inst  = dec_valid ? mem[rd_ptr] : '0;

   // mdr_taken still pulses on a flushed read: the MDR word was consumed either way.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         mdr_taken <= 1'b0;
      end else begin
         mdr_taken <= (state == READ);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= inst;
   end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Scoreboard bench for inst_fetch_buffer: a source model feeds the MDR side,
// expected words are queued by the stimulus and checked by a pop monitor.
module tb_inst_fetch_buffer;

   localparam int DEPTH = 4;
   localparam int WIDTH = 67;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             mdr_valid;
   logic             MDR_rd;
   logic [WIDTH-1:0] inst;
   logic             mdr_taken;
   logic             flush;
   logic [WIDTH-1:0] dec_inst;
   logic             dec_valid;
   logic             dec_ready;
   logic [CW-1:0]    count;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] src_q[$];
   logic [WIDTH-1:0] exp_q[$];
   logic             src_en = 1'b0;

   inst_fetch_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .mdr_valid(mdr_valid), .MDR_rd(MDR_rd), .inst(inst),
      .mdr_taken(mdr_taken), .flush(flush), .dec_inst(dec_inst), .dec_valid(dec_valid),
      .dec_ready(dec_ready), .count(count)
   );

   always #5 clk = ~clk;

   // Upstream MDR model: retire the word once it has been taken, present the next one.
   always @(negedge clk) begin
      if (mdr_taken && src_q.size() > 0) void'(src_q.pop_front());
      mdr_valid = src_en && (src_q.size() > 0);
      inst      = (src_q.size() > 0) ? src_q[0] : '0;
   end

   // Pop monitor: every accepted decode word must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && !flush && dec_valid && dec_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %0h, required no word", dec_inst);
         end else begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            if (dec_inst !== e) begin
               errors++;
               $display("FAIL pop_data: got %0h, required %0h", dec_inst, e);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [127:0] got, input logic [127:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, got, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rd(input string nm);
      int n;
      n = 0;
      while (!MDR_rd && n < 30) begin
         tick();
         n++;
      end
      check(nm, MDR_rd, 1'b1);
   endtask

   task automatic wait_count(input string nm, input int c);
      int n;
      n = 0;
      while (count != CW'(c) && n < 40) begin
         tick();
         n++;
      end
      check(nm, count, c);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_mdr_rd"},    MDR_rd,    0);
      check({nm, "_taken"},     mdr_taken, 0);
      check({nm, "_dec_valid"}, dec_valid, 0);
      check({nm, "_dec_inst"},  dec_inst,  0);
      check({nm, "_count"},     count,     0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] w;
      int pulses, maxc, n;
      rst = 1'b1; flush = 1'b0; dec_ready = 1'b0; mdr_valid = 1'b0; inst = '0;
      tick(); tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      src_en = 1'b1;

      // Single word
      w = 67'h1_2345_6789_ABCD_EF01;
      src_q.push_back(w); exp_q.push_back(w);
      wait_rd("single_rd_seen");
      tick();
      check("single_rd_one_cycle", MDR_rd, 0);
      check("single_taken", mdr_taken, 1);
      check("single_valid", dec_valid, 1);
      check("single_inst", dec_inst, w);
      check("single_count", count, 1);
      tick();
      check("single_taken_pulse", mdr_taken, 0);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      check("single_drained", count, 0);

      // Fill to full with words 1..6
      for (int i = 1; i <= 6; i++) begin
         src_q.push_back(WIDTH'(i)); exp_q.push_back(WIDTH'(i));
      end
      pulses = 0; maxc = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (MDR_rd) pulses++;
         if (count > maxc) maxc = count;
      end
      check("fill_pulses", pulses, 4);
      check("fill_count", count, 4);
      check("fill_max", maxc, 4);
      check("fill_rd_idle", MDR_rd, 0);
      check("fill_head", dec_inst, 1);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      check("fill_after_pop", count, 3);
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (MDR_rd) pulses++;
      end
      check("refill_pulses", pulses, 1);
      check("refill_count", count, 4);
      dec_ready = 1'b1;
      n = 0;
      while ((count != 0 || src_q.size() != 0) && n < 60) begin tick(); n++; end
      dec_ready = 1'b0;
      check("fill_drain_done", exp_q.size(), 0);

      // Wrap-around streaming: 20 distinct words
      dec_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         w = {3'b101, 64'hA5A5_0000_0000_0000 + 64'(i * 17)};
         src_q.push_back(w); exp_q.push_back(w);
      end
      maxc = 0; n = 0;
      while ((exp_q.size() != 0 || count != 0) && n < 150) begin
         tick();
         if (count > maxc) maxc = count;
         n++;
      end
      dec_ready = 1'b0;
      check("stream_all_delivered", exp_q.size(), 0);
      check("stream_max_count", maxc, 1);

      // Flush during READ with two words queued
      src_q.push_back(67'h4_0000_0000_0000_00AA); src_q.push_back(67'h4_0000_0000_0000_00BB);
      exp_q.push_back(67'h4_0000_0000_0000_00AA); exp_q.push_back(67'h4_0000_0000_0000_00BB);
      wait_count("flush_setup_count", 2);
      src_q.push_back(67'h7_DEAD_0000_0000_0000); src_q.push_back(67'h2_0000_0000_0000_00DD);
      wait_rd("flush_rd_seen");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_q.delete();
      exp_q.push_back(67'h2_0000_0000_0000_00DD);
      check("flush_count", count, 0);
      check("flush_valid", dec_valid, 0);
      check("flush_inst", dec_inst, 0);
      check("flush_taken", mdr_taken, 1);
      wait_count("flush_next_count", 1);
      check("flush_next_inst", dec_inst, 67'h2_0000_0000_0000_00DD);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      check("flush_scoreboard_empty", exp_q.size(), 0);

      // Simultaneous push and pop
      src_q.push_back(67'h3_1111_0000_0000_0001); exp_q.push_back(67'h3_1111_0000_0000_0001);
      wait_count("pp_setup_count", 1);
      src_q.push_back(67'h3_2222_0000_0000_0002); exp_q.push_back(67'h3_2222_0000_0000_0002);
      wait_rd("pp_rd_seen");
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      check("pp_count", count, 1);
      check("pp_inst", dec_inst, 67'h3_2222_0000_0000_0002);
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      check("pp_scoreboard_empty", exp_q.size(), 0);

      // Reset while READ is active
      src_q.push_back(67'h6_6666_6666_6666_6666);
      wait_rd("rst_rd_seen");
      rst = 1'b1;
      src_en = 1'b0;
      src_q.delete();
      tick();
      check_reset_outputs("rst_mid_read");
      rst = 1'b0;
      tick();
      check("rst_no_taken", mdr_taken, 0);
      check("rst_count_stays", count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
